// File: rtl/bpu_sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bpu_sram_pkg : shared defaults, state encoding and write-request type |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bpu_sram_pkg;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 53;
    localparam int DEPTH      = 128;
    localparam int STARVE_MAX = 3;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wreq_t;
endpackage
`default_nettype wire

// File: rtl/bpu_sram_port_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bpu_sram_port_ctrl_if : request/response channels plus RW0 array port |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bpu_sram_port_ctrl_if #(
    parameter int ADDR_W = bpu_sram_pkg::ADDR_W,
    parameter int DATA_W = bpu_sram_pkg::DATA_W
);
    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              w_req_valid;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic              init_done;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [ADDR_W-1:0] RW0_addr;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    // Controller view
    modport slave (
        input  r_req_valid, r_req_addr, w_req_valid, w_req_addr, w_req_data, RW0_rdata,
        output r_req_ready, r_resp_valid, r_resp_data, w_req_ready, init_done,
               RW0_en, RW0_wmode, RW0_addr, RW0_wdata
    );

    // Requester plus array view
    modport master (
        output r_req_valid, r_req_addr, w_req_valid, w_req_addr, w_req_data, RW0_rdata,
        input  r_req_ready, r_resp_valid, r_resp_data, w_req_ready, init_done,
               RW0_en, RW0_wmode, RW0_addr, RW0_wdata
    );
endinterface
`default_nettype wire

// File: rtl/bpu_sram_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bpu_sram_wbuf : one-entry write buffer with read-starvation counter  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bpu_sram_wbuf #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 53,
    parameter int STARVE_MAX = 3
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              run,
    input  wire logic              r_fire,
    input  wire logic              w_req_valid,
    input  wire logic [ADDR_W-1:0] w_req_addr,
    input  wire logic [DATA_W-1:0] w_req_data,
    output logic                   w_req_ready,
    output logic                   wb_valid,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   force_write
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic             drain;
    logic             w_fire;
    logic [CNT_W-1:0] starve_q;

    // The port only idles for the buffer when no read claims it this cycle
    assign drain       = run && wb_valid && !r_fire;
    assign w_req_ready = run && (!wb_valid || drain);
    assign w_fire      = w_req_valid && w_req_ready;
    assign force_write = (starve_q == CNT_W'(STARVE_MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            starve_q <= '0;
        end else begin
            if (w_fire) begin
                wb_valid <= 1'b1;
                wb_addr  <= w_req_addr;
                wb_data  <= w_req_data;
            end else if (drain) begin
                wb_valid <= 1'b0;
            end
            if (drain)
                starve_q <= '0;
            else if (wb_valid && r_fire)
                starve_q <= starve_q + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bpu_sram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bpu_sram_port_ctrl : arbitrates read/write channels onto the RW0 port |
// | with zero-fill after reset. Option macro: BPU_SRAM_RD_BYPASS_EN      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bpu_sram_port_ctrl #(
    parameter int ADDR_W     = bpu_sram_pkg::ADDR_W,
    parameter int DATA_W     = bpu_sram_pkg::DATA_W,
    parameter int DEPTH      = bpu_sram_pkg::DEPTH,
    parameter int STARVE_MAX = bpu_sram_pkg::STARVE_MAX
) (
    input  wire logic          clock,
    input  wire logic          reset,
    bpu_sram_port_ctrl_if.slave bus
);
    import bpu_sram_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              run, r_req_ready, r_fire, force_write;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              en, wmode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid_q;
    logic [DATA_W-1:0] hold_q, resp_src, resp_data;

    assign run         = (state_q == RUN);
    assign r_req_ready = run && !force_write;
    assign r_fire      = bus.r_req_valid && r_req_ready;

    bpu_sram_wbuf #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_wbuf (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .r_fire      (r_fire),
        .w_req_valid (bus.w_req_valid),
        .w_req_addr  (bus.w_req_addr),
        .w_req_data  (bus.w_req_data),
        .w_req_ready (bus.w_req_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .force_write (force_write)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        en      = 1'b0;
        wmode   = 1'b0;
        addr    = bus.r_req_addr;
        wdata   = wb_data;
        case (state_q)
            INIT: begin
                en    = 1'b1;
                wmode = 1'b1;
                addr  = init_cnt_q;
                wdata = '0;
                if (init_cnt_q == ADDR_W'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN: begin
                if (r_fire) begin
                    en = 1'b1;
                end else if (wb_valid) begin
                    en    = 1'b1;
                    wmode = 1'b1;
                    addr  = wb_addr;
                end
            end
            default: state_d = INIT;
        endcase
    end

`ifdef BPU_SRAM_RD_BYPASS_EN
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q <= r_fire && wb_valid && (bus.r_req_addr == wb_addr);
            if (r_fire)
                byp_data_q <= wb_data;
        end
    end

    assign resp_src = byp_hit_q ? byp_data_q : bus.RW0_rdata;
`else
    assign resp_src = bus.RW0_rdata;
`endif

    // Macro output follows its latched address, so the response is frozen in hold_q
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            resp_valid_q <= r_fire;
            if (resp_valid_q)
                hold_q <= resp_src;
        end
    end

    assign resp_data = resp_valid_q ? resp_src : hold_q;

    assign bus.r_req_ready  = r_req_ready;
    assign bus.r_resp_valid = resp_valid_q;
    assign bus.r_resp_data  = resp_data;
    assign bus.init_done    = run;
    assign bus.RW0_en       = en;
    assign bus.RW0_wmode    = wmode;
    assign bus.RW0_addr     = addr;
    assign bus.RW0_wdata    = wdata;
endmodule
`default_nettype wire

// File: tb/tb_bpu_sram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bpu_sram_port_ctrl : directed vectors against a behavioural macro |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_bpu_sram_port_ctrl;
    localparam int AW = 7;
    localparam int DW = 53;
    localparam int DP = 128;
    localparam int NV = 26;

    localparam logic [DW-1:0] D1 = 53'h1_2345_6789_ABCD;
    localparam logic [DW-1:0] W2 = 53'h0A_BCDE_F012_3456;
`ifdef BPU_SRAM_RD_BYPASS_EN
    localparam logic [DW-1:0] BYP5 = 53'h11;
`else
    localparam logic [DW-1:0] BYP5 = 53'h0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bpu_sram_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bpu_sram_port_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .STARVE_MAX(3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural macro: read output follows the latched address
    logic [DW-1:0] mem [DP];
    logic [AW-1:0] lat_addr = '0;
    always @(posedge clock) begin
        if (bus.RW0_en) begin
            if (bus.RW0_wmode) mem[bus.RW0_addr] <= bus.RW0_wdata;
            else               lat_addr <= bus.RW0_addr;
        end
    end
    assign bus.RW0_rdata = mem[lat_addr];

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rv;
        logic [AW-1:0] ra;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          e_rrdy;
        logic          e_wrdy;
        logic          e_rsv;
        logic [DW-1:0] e_rsd;
        logic          e_en;
        logic          e_wm;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic rv, logic [AW-1:0] ra, logic wv, logic [AW-1:0] wa,
                                logic [DW-1:0] wd, logic rr, logic wr, logic rsv,
                                logic [DW-1:0] rsd, logic en, logic wm, logic [AW-1:0] ad);
        vec_t v;
        v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
        v.e_rrdy = rr; v.e_wrdy = wr; v.e_rsv = rsv; v.e_rsd = rsd;
        v.e_en = en; v.e_wm = wm; v.e_addr = ad;
        return v;
    endfunction

    task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic wv,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bus.r_req_valid = rv;
        bus.r_req_addr  = ra;
        bus.w_req_valid = wv;
        bus.w_req_addr  = wa;
        bus.w_req_data  = wd;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " init_done"}, bus.init_done, 0);
        chk({tag, " r_req_ready"}, bus.r_req_ready, 0);
        chk({tag, " w_req_ready"}, bus.w_req_ready, 0);
        chk({tag, " r_resp_valid"}, bus.r_resp_valid, 0);
        chk({tag, " r_resp_data"}, bus.r_resp_data, 0);
        chk({tag, " RW0 en/wmode/addr/wdata"},
            {bus.RW0_en, bus.RW0_wmode, 7'(bus.RW0_addr), 53'(bus.RW0_wdata)}, {2'b11, 60'h0});
    endtask

    // Entered on the negedge where reset has just been released
    task automatic do_init(input string tag);
        for (int i = 0; i < DP; i++) begin
            #1;
            chk($sformatf("%s fill_addr[%0d]", tag, i), bus.RW0_addr, i);
            chk($sformatf("%s fill_ctl[%0d]", tag, i),
                {bus.init_done, bus.r_req_ready, bus.w_req_ready, bus.RW0_en, bus.RW0_wmode,
                 (bus.RW0_wdata == '0)}, 6'b000111);
            @(negedge clock);
        end
        #1;
        chk({tag, " init_done"}, bus.init_done, 1);
    endtask

    task automatic read_one(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clock);
        drive(1'b1, a, 1'b0, '0, '0);
        #1;
        chk({tag, " r_req_ready"}, bus.r_req_ready, 1);
        @(negedge clock);
        drive(1'b0, '0, 1'b0, '0, '0);
        #1;
        chk({tag, " r_resp_valid"}, bus.r_resp_valid, 1);
        chk({tag, " r_resp_data"}, bus.r_resp_data, exp);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < DP; i++) mem[i] <= '1;

        vecs[0]  = mk(0, 0, 1, 3, D1,     1, 1, 0, 0,     0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0,      1, 1, 0, 0,     1, 1, 3);
        vecs[2]  = mk(0, 0, 0, 0, 0,      1, 1, 0, 0,     0, 0, 0);
        vecs[3]  = mk(1, 3, 0, 0, 0,      1, 1, 0, 0,     1, 0, 3);
        vecs[4]  = mk(0, 0, 0, 0, 0,      1, 1, 1, D1,    0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0,      1, 1, 0, D1,    0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 7, 'hAA,   1, 1, 0, D1,    0, 0, 0);
        vecs[7]  = mk(1, 9, 0, 0, 0,      1, 0, 0, D1,    1, 0, 9);
        vecs[8]  = mk(1, 9, 0, 0, 0,      1, 0, 1, 0,     1, 0, 9);
        vecs[9]  = mk(1, 9, 0, 0, 0,      1, 0, 1, 0,     1, 0, 9);
        vecs[10] = mk(1, 9, 0, 0, 0,      0, 1, 1, 0,     1, 1, 7);
        vecs[11] = mk(1, 9, 0, 0, 0,      1, 1, 0, 0,     1, 0, 9);
        vecs[12] = mk(0, 0, 0, 0, 0,      1, 1, 1, 0,     0, 0, 0);
        vecs[13] = mk(0, 0, 1, 5, 'h11,   1, 1, 0, 0,     0, 0, 0);
        vecs[14] = mk(1, 5, 0, 0, 0,      1, 0, 0, 0,     1, 0, 5);
        vecs[15] = mk(0, 0, 0, 0, 0,      1, 1, 1, BYP5,  1, 1, 5);
        vecs[16] = mk(0, 0, 0, 0, 0,      1, 1, 0, BYP5,  0, 0, 0);
        vecs[17] = mk(1, 5, 0, 0, 0,      1, 1, 0, BYP5,  1, 0, 5);
        vecs[18] = mk(0, 0, 0, 0, 0,      1, 1, 1, 'h11,  0, 0, 0);
        vecs[19] = mk(1, 2, 1, 2, W2,     1, 1, 0, 'h11,  1, 0, 2);
        vecs[20] = mk(0, 0, 0, 0, 0,      1, 1, 1, 0,     1, 1, 2);
        vecs[21] = mk(1, 2, 0, 0, 0,      1, 1, 0, 0,     1, 0, 2);
        vecs[22] = mk(0, 0, 0, 0, 0,      1, 1, 1, W2,    0, 0, 0);
        vecs[23] = mk(0, 0, 1, 2, 'h5,    1, 1, 0, W2,    0, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0,      1, 1, 0, W2,    1, 1, 2);
        vecs[25] = mk(0, 0, 0, 0, 0,      1, 1, 0, W2,    0, 0, 0);

        @(negedge clock);
        @(negedge clock);
        #1;
        chk_reset_vals("por");
        @(negedge clock);
        reset = 1'b0;
        do_init("fill1");
        for (int i = 0; i < DP; i++) chk($sformatf("mem_zero[%0d]", i), mem[i], 0);

        read_one("rd55", 7'h55, '0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd);
            #1;
            chk($sformatf("vec%0d r_req_ready", i), bus.r_req_ready, vecs[i].e_rrdy);
            chk($sformatf("vec%0d w_req_ready", i), bus.w_req_ready, vecs[i].e_wrdy);
            chk($sformatf("vec%0d r_resp_valid", i), bus.r_resp_valid, vecs[i].e_rsv);
            chk($sformatf("vec%0d r_resp_data", i), bus.r_resp_data, vecs[i].e_rsd);
            chk($sformatf("vec%0d RW0_en", i), bus.RW0_en, vecs[i].e_en);
            if (vecs[i].e_en)
                chk($sformatf("vec%0d RW0_wmode/addr", i),
                    {bus.RW0_wmode, bus.RW0_addr}, {vecs[i].e_wm, vecs[i].e_addr});
        end

        // Reset with a buffered write and a response in flight
        @(negedge clock);
        drive(1'b1, 7'h02, 1'b1, 7'h10, 53'h77);
        @(negedge clock);
        drive(1'b0, '0, 1'b0, '0, '0);
        #1;
        chk("midrst pre r_resp_valid", bus.r_resp_valid, 1);
        chk("midrst pre r_resp_data", bus.r_resp_data, 53'h5);
        chk("midrst pre drain", {bus.RW0_en, bus.RW0_wmode, bus.RW0_addr}, {2'b11, 7'h10});
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clock);
        reset = 1'b0;
        do_init("fill2");
        read_one("rd10_after_rst", 7'h10, '0);
        read_one("rd02_after_rst", 7'h02, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
`default_nettype wire
